// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial TDM receive bundle between a bit source and tdm_demux.
//   master modport : drives iEnb/iSync/iD, observes the deserializer outputs
//   slave  modport : the deserializer (tdm_demux)
// Signals:
//   iEnb       bit-slot enable, active-low (1 = no bit this cycle)
//   iSync      frame-start marker, accompanies lane 0 bit 0
//   iD         serial data bit
//   oLane      assembled words, lane k at [k*WIDTH +: WIDTH]
//   oFrameDone one-cycle pulse, oLane carries a new frame
//   oBusy      frame reception in progress
//   oErr       one-cycle pulse, iSync seen mid-frame
//   oParErr    one-cycle pulse, parity mismatch (0 unless parity is built in)
interface tdm_demux_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8
);
  logic                     iEnb;
  logic                     iSync;
  logic                     iD;
  logic [LANES*WIDTH-1:0]   oLane;
  logic                     oFrameDone;
  logic                     oBusy;
  logic                     oErr;
  logic                     oParErr;

  modport master (
    output iEnb, iSync, iD,
    input  oLane, oFrameDone, oBusy, oErr, oParErr
  );

  modport slave (
    input  iEnb, iSync, iD,
    output oLane, oFrameDone, oBusy, oErr, oParErr
  );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: time-division demultiplexer / deserializer for the serial TDM link.
// One serial bit is consumed per cycle with iEnb=0. Bit n of a frame lands in
// lane n mod LANES at bit position n / LANES, so every lane fills LSB first.
// A completed frame is presented on oLane with a one-cycle oFrameDone pulse.
// Ports:
//   iClk  clock, rising edge
//   iClr  asynchronous active-high reset
//   tdm   tdm_demux_if.slave bundle (iEnb, iSync, iD in; oLane, oFrameDone,
//         oBusy, oErr, oParErr out)
// Build option: define TDM_DEMUX_PARITY_EN to append one even-parity bit per
// frame (PAR state); otherwise oParErr is tied low.
module tdm_demux #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic        iClk,
  input  logic        iClr,
  tdm_demux_if.slave  tdm
);

  localparam int unsigned FRAME  = LANES * WIDTH;
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned IDX_W  = $clog2(FRAME);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_PAR  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [LANE_W-1:0]   r_lane_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [FRAME-1:0]    r_shift;
  logic [FRAME-1:0]    r_lane;
  logic                r_frame_done;
  logic                r_busy;
  logic                r_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic                r_par;
  logic                r_par_err;
`endif

  logic                w_take;
  logic                w_sync;
  logic                w_last;
  logic [IDX_W-1:0]    w_idx;
  logic [FRAME-1:0]    w_shift_nxt;

  // A slot carries a bit only when iEnb is low; iSync alone is meaningless.
  assign w_take = ~tdm.iEnb;
  assign w_sync = w_take & tdm.iSync;
  assign w_last = (r_lane_cnt == LANE_W'(LANES - 1)) &&
                  (r_bit_cnt  == BIT_W'(WIDTH - 1));

  // Flat position of the current bit: lane base plus in-lane bit index.
  assign w_idx = (IDX_W'(r_lane_cnt) * IDX_W'(WIDTH)) + IDX_W'(r_bit_cnt);

  // Shift register image with the current bit written into its slot.
  always_comb begin
    w_shift_nxt        = r_shift;
    w_shift_nxt[w_idx] = tdm.iD;
  end

  // Receive FSM, counters and registered outputs.
  always_ff @(posedge iClk or posedge iClr) begin
    if (iClr) begin
      r_state      <= S_IDLE;
      r_lane_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_lane       <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_par        <= 1'b0;
      r_par_err    <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_par_err    <= 1'b0;
`endif
      if (w_sync && (r_state != S_DONE)) begin
        // Frame start; mid-frame it also drops the partial frame and flags it.
        r_err      <= (r_state != S_IDLE);
        r_shift    <= FRAME'(tdm.iD);
        r_lane_cnt <= LANE_W'(1);
        r_bit_cnt  <= '0;
        r_busy     <= 1'b1;
        r_state    <= S_RECV;
`ifdef TDM_DEMUX_PARITY_EN
        r_par      <= tdm.iD;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            r_busy <= 1'b0;
          end

          S_RECV: begin
            if (w_take) begin
              r_shift <= w_shift_nxt;
`ifdef TDM_DEMUX_PARITY_EN
              r_par   <= r_par ^ tdm.iD;
`endif
              if (w_last) begin
                r_lane_cnt <= '0;
                r_bit_cnt  <= '0;
`ifdef TDM_DEMUX_PARITY_EN
                r_state    <= S_PAR;
`else
                // Outputs load on entry to DONE so they show during DONE.
                r_lane       <= w_shift_nxt;
                r_frame_done <= 1'b1;
                r_busy       <= 1'b0;
                r_state      <= S_DONE;
`endif
              end else if (r_lane_cnt == LANE_W'(LANES - 1)) begin
                r_lane_cnt <= '0;
                r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
              end else begin
                r_lane_cnt <= r_lane_cnt + LANE_W'(1);
              end
            end
          end

`ifdef TDM_DEMUX_PARITY_EN
          S_PAR: begin
            if (w_take) begin
              r_busy <= 1'b0;
              if (tdm.iD == r_par) begin
                r_lane       <= r_shift;
                r_frame_done <= 1'b1;
                r_state      <= S_DONE;
              end else begin
                r_par_err <= 1'b1;
                r_state   <= S_IDLE;
              end
            end
          end
`endif

          S_DONE: begin
            // Single cycle regardless of iEnb; iSync here is dropped.
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end

          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tdm.oLane      = r_lane;
  assign tdm.oFrameDone = r_frame_done;
  assign tdm.oBusy      = r_busy;
  assign tdm.oErr       = r_err;
`ifdef TDM_DEMUX_PARITY_EN
  assign tdm.oParErr    = r_par_err;
`else
  assign tdm.oParErr    = 1'b0;
`endif

endmodule
